// File: rtl/exc_ctl_pkg.sv
// -----------------------------------------------------------------------------
// exc_ctl_pkg
//   Shared constants and types for the exception/interrupt sequencer:
//   CPR port encodings, the CPR indices that the sequencer owns, the
//   interrupt cause code, the sequencer state enum and the latched
//   exception record.
// -----------------------------------------------------------------------------
package exc_ctl_pkg;

  localparam int CPR_IDX_BITS   = 5;
  localparam int CPR_CAUSE_BITS = 5;

  // MFPR / MTPR operation select on the CPR port
  localparam logic CPR_MF = 1'b0;
  localparam logic CPR_MT = 1'b1;

  // CPR indices answered by the interrupt pending/mask block
  localparam logic [CPR_IDX_BITS-1:0] CPR_IMASK = 5'd12;
  localparam logic [CPR_IDX_BITS-1:0] CPR_IPND  = 5'd13;

  // Cause code reported for an external interrupt entry
  localparam logic [CPR_CAUSE_BITS-1:0] CAUSE_IRQ = 5'd16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FLUSH_IN  = 3'd1,
    ST_ENTER     = 3'd2,
    ST_FLUSH_OUT = 3'd3,
    ST_EXIT      = 3'd4,
    ST_HALT      = 3'd5
  } exc_state_t;

  // Record handed to the CPR block on exception entry
  typedef struct packed {
    logic [63:0]               epc;
    logic [31:0]               inst;
    logic [CPR_CAUSE_BITS-1:0] cause;
  } exc_rec_t;

endpackage

// File: rtl/exc_ctl_irq_pend.sv
// -----------------------------------------------------------------------------
// irq_pend
//   IMASK / IPND control registers behind the MFPR/MTPR port.
//   - IPND: sticky per-line pending bits, set every cycle the line is high,
//     cleared by MTPR write-1-to-clear (a same-cycle set wins).
//   - IMASK: loaded from MTPR data, all lines masked out of reset.
//   - MFPR data and rvalid are registered: they appear the cycle after the
//     access strobe.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   enable            CPR access strobe
//   cpr_op            CPR_MF / CPR_MT
//   cpr_idx           CPR index (only CPR_IMASK / CPR_IPND respond)
//   cpr_wdata         MTPR data
//   irq_lines         level-sensitive interrupt requests
//   rvalid, result    registered MFPR response
//   irq_req_raw       some pending line is unmasked (before the emode gate)
// -----------------------------------------------------------------------------
module irq_pend
  import exc_ctl_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cpr_op,
  input  logic [CPR_IDX_BITS-1:0] cpr_idx,
  input  logic [63:0]             cpr_wdata,
  input  logic [N_IRQ-1:0]        irq_lines,
  output logic                    rvalid,
  output logic [63:0]             result,
  output logic                    irq_req_raw
);

  logic [N_IRQ-1:0] imask_q, imask_d;
  logic [N_IRQ-1:0] ipnd_q,  ipnd_d;
  logic [63:0]      result_q, result_d;
  logic             rvalid_q;

  logic mt_imask, mt_ipnd, mf_access;

  assign mt_imask  = enable && (cpr_op == CPR_MT) && (cpr_idx == CPR_IMASK);
  assign mt_ipnd   = enable && (cpr_op == CPR_MT) && (cpr_idx == CPR_IPND);
  assign mf_access = enable && (cpr_op == CPR_MF);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    imask_d  = imask_q;
    ipnd_d   = ipnd_q;
    result_d = '0;

    if (mt_imask) imask_d = cpr_wdata[N_IRQ-1:0];

    // Clear first, then OR in the live lines so a same-cycle set survives.
    if (mt_ipnd) ipnd_d = ipnd_q & ~cpr_wdata[N_IRQ-1:0];
    ipnd_d = ipnd_d | irq_lines;

    // Reads see the register values before this cycle's update.
    if (mf_access) begin
      unique case (cpr_idx)
        CPR_IMASK: result_d = {{(64-N_IRQ){1'b0}}, imask_q};
        CPR_IPND:  result_d = {{(64-N_IRQ){1'b0}}, ipnd_q};
        default:   result_d = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imask_q  <= '0;
      ipnd_q   <= '0;
      result_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      imask_q  <= imask_d;
      ipnd_q   <= ipnd_d;
      result_q <= result_d;
      rvalid_q <= enable;
    end
  end

  assign rvalid      = rvalid_q;
  assign result      = result_q;
  assign irq_req_raw = |(ipnd_q & imask_q);

endmodule

// File: rtl/exc_ctl.sv
// -----------------------------------------------------------------------------
// exc_ctl
//   Exception/interrupt sequencer. Arbitrates graduation faults, unmasked
//   external interrupts and return-from-exception, flushes and drains the
//   pipeline, then pulses e_enter / e_exit to the CPR block and redirects
//   fetch. A fault taken while already in exception mode halts the core.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   enable/cpr_op/cpr_idx/
//   cpr_wdata/rvalid/result    MFPR/MTPR port for IMASK and IPND
//   fault_valid/pc/inst/cause  graduating faulted instruction
//   next_pc                    PC of the oldest non-graduated instruction
//   irq_lines                  level-sensitive interrupt requests
//   rei_valid, rei_pc          return-from-exception and its target
//   pipe_flush, pipe_drained   flush request / pipeline empty handshake
//   redirect_valid/pc          one-cycle fetch redirect
//   e_enter, e_exit            one-cycle pulses to the CPR block
//   n_epc/n_inst/n_cause       latched exception record
//   emode, halted, busy        status
// -----------------------------------------------------------------------------
module exc_ctl
  import exc_ctl_pkg::*;
#(
  parameter int          N_IRQ  = 8,
  parameter logic [63:0] VEC_PC = 64'h0000_0000_0000_0100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      cpr_op,
  input  logic [CPR_IDX_BITS-1:0]   cpr_idx,
  input  logic [63:0]               cpr_wdata,
  output logic                      rvalid,
  output logic [63:0]               result,
  input  logic                      fault_valid,
  input  logic [63:0]               fault_pc,
  input  logic [31:0]               fault_inst,
  input  logic [CPR_CAUSE_BITS-1:0] fault_cause,
  input  logic [63:0]               next_pc,
  input  logic [N_IRQ-1:0]          irq_lines,
  input  logic                      rei_valid,
  input  logic [63:0]               rei_pc,
  output logic                      pipe_flush,
  input  logic                      pipe_drained,
  output logic                      redirect_valid,
  output logic [63:0]               redirect_pc,
  output logic                      e_enter,
  output logic                      e_exit,
  output logic [63:0]               n_epc,
  output logic [31:0]               n_inst,
  output logic [CPR_CAUSE_BITS-1:0] n_cause,
  output logic                      emode,
  output logic                      halted,
  output logic                      busy
);

  exc_state_t  state_q, state_d;
  logic        emode_q, emode_d;
  exc_rec_t    rec_q, rec_d;
  logic [63:0] rei_pc_q, rei_pc_d;

  logic irq_req_raw, irq_req;

  irq_pend #(.N_IRQ(N_IRQ)) u_irq_pend (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cpr_op      (cpr_op),
    .cpr_idx     (cpr_idx),
    .cpr_wdata   (cpr_wdata),
    .irq_lines   (irq_lines),
    .rvalid      (rvalid),
    .result      (result),
    .irq_req_raw (irq_req_raw)
  );

  // Interrupts are held off for the whole time the core is in exception mode.
  assign irq_req = irq_req_raw && !emode_q;

  always_comb begin
    state_d        = state_q;
    emode_d        = emode_q;
    rec_d          = rec_q;
    rei_pc_d       = rei_pc_q;
    pipe_flush     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    e_enter        = 1'b0;
    e_exit         = 1'b0;
    halted         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fault_valid && emode_q) begin
          state_d = ST_HALT;
        end else if (fault_valid) begin
          rec_d   = '{epc: fault_pc, inst: fault_inst, cause: fault_cause};
          state_d = ST_FLUSH_IN;
        end else if (irq_req) begin
          rec_d   = '{epc: next_pc, inst: 32'd0, cause: CAUSE_IRQ};
          state_d = ST_FLUSH_IN;
        end else if (rei_valid && emode_q) begin
          rei_pc_d = rei_pc;
          state_d  = ST_FLUSH_OUT;
        end
      end
      ST_FLUSH_IN: begin
        pipe_flush = 1'b1;
        if (pipe_drained) state_d = ST_ENTER;
      end
      ST_ENTER: begin
        e_enter        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = VEC_PC;
        emode_d        = 1'b1;
        state_d        = ST_IDLE;
      end
      ST_FLUSH_OUT: begin
        pipe_flush = 1'b1;
        if (pipe_drained) state_d = ST_EXIT;
      end
      ST_EXIT: begin
        e_exit         = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = rei_pc_q;
        emode_d        = 1'b0;
        state_d        = ST_IDLE;
      end
      ST_HALT: begin
        // Terminal: keeps the pipe frozen until reset.
        pipe_flush = 1'b1;
        halted     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the record and rei target are control-path registers, not memory,
  // so they are reset to keep n_epc/n_inst/n_cause at zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      emode_q  <= 1'b1;     // CPR block also comes out of reset in exception mode
      rec_q    <= '0;
      rei_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      emode_q  <= emode_d;
      rec_q    <= rec_d;
      rei_pc_q <= rei_pc_d;
    end
  end

  assign n_epc   = rec_q.epc;
  assign n_inst  = rec_q.inst;
  assign n_cause = rec_q.cause;
  assign emode   = emode_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exc_ctl.sv
// -----------------------------------------------------------------------------
// tb_exc_ctl
//   Directed bench for exc_ctl: a table of CPR-port vectors for IMASK/IPND,
//   followed by hand-written sequences for the exception entry/exit paths,
//   interrupt masking, fault/irq collision, double fault and async reset.
// -----------------------------------------------------------------------------
module tb_exc_ctl;
  import exc_ctl_pkg::*;

  localparam int          N_IRQ  = 8;
  localparam logic [63:0] VEC_PC = 64'h0000_0000_0000_0100;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      enable;
  logic                      cpr_op;
  logic [CPR_IDX_BITS-1:0]   cpr_idx;
  logic [63:0]               cpr_wdata;
  logic                      rvalid;
  logic [63:0]               result;
  logic                      fault_valid;
  logic [63:0]               fault_pc;
  logic [31:0]               fault_inst;
  logic [CPR_CAUSE_BITS-1:0] fault_cause;
  logic [63:0]               next_pc;
  logic [N_IRQ-1:0]          irq_lines;
  logic                      rei_valid;
  logic [63:0]               rei_pc;
  logic                      pipe_flush;
  logic                      pipe_drained;
  logic                      redirect_valid;
  logic [63:0]               redirect_pc;
  logic                      e_enter;
  logic                      e_exit;
  logic [63:0]               n_epc;
  logic [31:0]               n_inst;
  logic [CPR_CAUSE_BITS-1:0] n_cause;
  logic                      emode;
  logic                      halted;
  logic                      busy;

  int n_cmp = 0;
  int n_bad = 0;

  exc_ctl #(.N_IRQ(N_IRQ), .VEC_PC(VEC_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .cpr_op         (cpr_op),
    .cpr_idx        (cpr_idx),
    .cpr_wdata      (cpr_wdata),
    .rvalid         (rvalid),
    .result         (result),
    .fault_valid    (fault_valid),
    .fault_pc       (fault_pc),
    .fault_inst     (fault_inst),
    .fault_cause    (fault_cause),
    .next_pc        (next_pc),
    .irq_lines      (irq_lines),
    .rei_valid      (rei_valid),
    .rei_pc         (rei_pc),
    .pipe_flush     (pipe_flush),
    .pipe_drained   (pipe_drained),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .e_enter        (e_enter),
    .e_exit         (e_exit),
    .n_epc          (n_epc),
    .n_inst         (n_inst),
    .n_cause        (n_cause),
    .emode          (emode),
    .halted         (halted),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_exit(input logic [63:0] pc);
    rei_valid    = 1'b1;
    rei_pc       = pc;
    pipe_drained = 1'b1;
    step();
    rei_valid = 1'b0;
    check("exit_flush", pipe_flush, 1);
    check("exit_no_pulse_yet", e_exit, 0);
    step();
    check("exit_pulse", e_exit, 1);
    check("exit_redirect_v", redirect_valid, 1);
    check("exit_redirect_pc", redirect_pc, pc);
    check("exit_no_enter", e_enter, 0);
    step();
    check("exit_emode_clr", emode, 0);
    check("exit_pulse_end", redirect_valid, 0);
    check("exit_idle", busy, 0);
  endtask

  typedef struct {
    logic              en;
    logic              op;
    logic [4:0]        idx;
    logic [63:0]       wdata;
    logic [7:0]        irq;
    logic              exp_rvalid;
    logic [63:0]       exp_result;
  } cpr_vec_t;

  cpr_vec_t vecs[11];

  initial begin
    // Table of CPR accesses, applied while emode=1 so no entry can start.
    vecs[0]  = '{1'b1, CPR_MT, CPR_IMASK, 64'h04,                  8'h00, 1'b1, 64'h0};
    vecs[1]  = '{1'b1, CPR_MF, CPR_IMASK, 64'h0,                   8'h00, 1'b1, 64'h04};
    vecs[2]  = '{1'b0, CPR_MF, CPR_IPND,  64'h0,                   8'h0A, 1'b0, 64'h0};
    vecs[3]  = '{1'b1, CPR_MF, CPR_IPND,  64'h0,                   8'h00, 1'b1, 64'h0A};
    vecs[4]  = '{1'b1, CPR_MT, CPR_IPND,  64'h0A,                  8'h08, 1'b1, 64'h0};
    vecs[5]  = '{1'b1, CPR_MF, CPR_IPND,  64'h0,                   8'h00, 1'b1, 64'h08};
    vecs[6]  = '{1'b1, CPR_MF, 5'd3,      64'h0,                   8'h00, 1'b1, 64'h0};
    vecs[7]  = '{1'b1, CPR_MT, CPR_IPND,  64'hFF,                  8'h00, 1'b1, 64'h0};
    vecs[8]  = '{1'b1, CPR_MF, CPR_IPND,  64'h0,                   8'h00, 1'b1, 64'h0};
    vecs[9]  = '{1'b1, CPR_MT, CPR_IMASK, 64'hFFFF_FFFF_FFFF_FF00, 8'h00, 1'b1, 64'h0};
    vecs[10] = '{1'b1, CPR_MF, CPR_IMASK, 64'h0,                   8'h00, 1'b1, 64'h0};

    reset = 1'b1; enable = 1'b0; cpr_op = CPR_MF; cpr_idx = '0; cpr_wdata = '0;
    fault_valid = 1'b0; fault_pc = '0; fault_inst = '0; fault_cause = '0;
    next_pc = 64'h5550; irq_lines = '0; rei_valid = 1'b0; rei_pc = '0;
    pipe_drained = 1'b0;
    step(); step();

    // ---- reset values ----
    check("rst_emode", emode, 1);
    check("rst_halted", halted, 0);
    check("rst_busy", busy, 0);
    check("rst_flush", pipe_flush, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_result", result, 0);
    check("rst_redirect", redirect_valid, 0);
    check("rst_n_epc", n_epc, 0);
    reset = 1'b0;
    step();

    // ---- CPR vector table ----
    for (int i = 0; i < 11; i++) begin
      enable    = vecs[i].en;
      cpr_op    = vecs[i].op;
      cpr_idx   = vecs[i].idx;
      cpr_wdata = vecs[i].wdata;
      irq_lines = vecs[i].irq;
      step();
      check($sformatf("vec%0d_rvalid", i), rvalid, vecs[i].exp_rvalid);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_result);
    end
    enable = 1'b0; irq_lines = '0;
    step();
    check("rvalid_falls", rvalid, 0);
    check("table_no_entry", busy, 0);

    // ---- exit from reset-time exception mode ----
    do_exit(64'h2000);

    // ---- fault entry with delayed drain ----
    pipe_drained = 1'b0;
    fault_valid = 1'b1; fault_pc = 64'h1234; fault_inst = 32'hDEADBEEF; fault_cause = 5'd3;
    step();
    fault_valid = 1'b0; fault_pc = '0; fault_inst = '0; fault_cause = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) pipe_drained = 1'b1;
      check($sformatf("fault_flush%0d", i), pipe_flush, 1);
      check($sformatf("fault_noenter%0d", i), e_enter, 0);
      step();
    end
    check("fault_enter", e_enter, 1);
    check("fault_epc", n_epc, 64'h1234);
    check("fault_inst", n_inst, 64'hDEADBEEF);
    check("fault_cause", n_cause, 3);
    check("fault_redirect_pc", redirect_pc, VEC_PC);
    check("fault_redirect_v", redirect_valid, 1);
    check("fault_no_exit", e_exit, 0);
    check("fault_no_flush", pipe_flush, 0);
    step();
    check("fault_emode", emode, 1);
    check("fault_enter_end", e_enter, 0);
    do_exit(64'h3000);

    // ---- interrupt masking ----
    irq_lines = 8'h04;
    step(); step(); step();
    check("irq_masked_idle", busy, 0);
    enable = 1'b1; cpr_op = CPR_MF; cpr_idx = CPR_IPND;
    step();
    check("irq_ipnd_read", result, 64'h4);
    cpr_op = CPR_MT; cpr_idx = CPR_IMASK; cpr_wdata = 64'h04;
    irq_lines = '0;
    step();
    enable = 1'b0;
    check("imask_t1_idle", busy, 0);
    step();
    check("imask_t2_flush", pipe_flush, 1);
    step();
    check("irq_enter", e_enter, 1);
    check("irq_epc", n_epc, 64'h5550);
    check("irq_inst", n_inst, 0);
    check("irq_cause", n_cause, CAUSE_IRQ);
    step();
    enable = 1'b1; cpr_op = CPR_MT; cpr_idx = CPR_IPND; cpr_wdata = 64'h4;
    step();
    cpr_op = CPR_MF;
    step();
    enable = 1'b0;
    check("ipnd_w1c_read", result, 0);
    do_exit(64'h4000);

    // ---- fault/irq collision: fault wins, irq waits for exit ----
    irq_lines = 8'h04;
    step();
    irq_lines = '0;
    fault_valid = 1'b1; fault_pc = 64'h7000; fault_cause = 5'd5;
    step();
    fault_valid = 1'b0;
    check("coll_flush", pipe_flush, 1);
    step();
    check("coll_enter", e_enter, 1);
    check("coll_cause", n_cause, 5);
    check("coll_epc", n_epc, 64'h7000);
    step();
    step();
    check("coll_irq_blocked", busy, 0);
    do_exit(64'h8000);
    step();
    check("coll_irq_flush", pipe_flush, 1);
    step();
    check("coll_irq_enter", e_enter, 1);
    check("coll_irq_cause", n_cause, CAUSE_IRQ);
    step();

    // ---- double fault ----
    fault_valid = 1'b1; fault_pc = 64'h9000;
    step();
    fault_valid = 1'b0;
    rei_valid = 1'b1; rei_pc = 64'hA000;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("halt_flag%0d", i), halted, 1);
      check($sformatf("halt_flush%0d", i), pipe_flush, 1);
      check($sformatf("halt_noenter%0d", i), e_enter | e_exit, 0);
      step();
    end
    rei_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("halt_reset_clears", halted, 0);
    step();
    reset = 1'b0;
    step();

    // ---- async reset during FLUSH_IN ----
    do_exit(64'h2000);
    pipe_drained = 1'b0;
    fault_valid = 1'b1; fault_pc = 64'hB000;
    step();
    fault_valid = 1'b0;
    check("arst_pre_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy_drop", busy, 0);
    check("arst_flush_drop", pipe_flush, 0);
    pipe_drained = 1'b1;
    step();
    check("arst_no_enter", e_enter, 0);
    check("arst_no_redirect", redirect_valid, 0);
    reset = 1'b0;
    step();
    check("arst_emode", emode, 1);
    check("arst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
